// File: rtl/ca_code_gen.sv
// C/A Gold code replica generator for one tracking channel.
// Consumes the half-chip strobe from the code NCO and produces early/prompt/late
// taps spaced one half-chip apart, full-chip and epoch strobes, PRN load, code
// slew by half-chip swallowing, and a TIC-latched code phase.
`timescale 1ns/1ps
module ca_code_gen #(
    parameter int         CODE_LEN = 1023,
    parameter logic [9:0] G1_INIT  = 10'h3FF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        hc_enable,
    input  logic        tic_enable,
    input  logic        prn_key_enable,
    input  logic [9:0]  prn_key,
    input  logic        slew_enable,
    input  logic [10:0] slew,
    output logic        fc_enable,
    output logic        dump_enable,
    output logic        early,
    output logic        prompt,
    output logic        late,
    output logic [10:0] code_phase,
    output logic        slew_busy
);

    localparam logic [9:0] LAST_CHIP = 10'(CODE_LEN - 1);

    logic [9:0]  g1;
    logic [9:0]  g2;
    logic [9:0]  chip_cnt;
    logic        hc_phase;
    logic [10:0] slew_cnt;
    logic        ca;
    logic        g1_fb;
    logic        g2_fb;
    logic        hc_eff;

    assign ca        = g1[9] ^ g2[9];
    assign g1_fb     = g1[2] ^ g1[9];
    assign g2_fb     = g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9];
    assign slew_busy = (slew_cnt != 11'd0);

    // A half-chip only advances the replica when no strobe or pending slew claims it.
    assign hc_eff = hc_enable & ~slew_busy & ~slew_enable & ~prn_key_enable;

    // Code generator state: priority is PRN load, slew load, slew swallow, then half-chip advance.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            g1          <= G1_INIT;
            g2          <= 10'd0;
            chip_cnt    <= 10'd0;
            hc_phase    <= 1'b0;
            slew_cnt    <= 11'd0;
            early       <= 1'b0;
            prompt      <= 1'b0;
            late        <= 1'b0;
            fc_enable   <= 1'b0;
            dump_enable <= 1'b0;
        end else begin
            fc_enable   <= 1'b0;
            dump_enable <= 1'b0;
            if (prn_key_enable) begin
                g1       <= G1_INIT;
                g2       <= prn_key;
                chip_cnt <= 10'd0;
                hc_phase <= 1'b0;
                slew_cnt <= 11'd0;
                early    <= 1'b0;
                prompt   <= 1'b0;
                late     <= 1'b0;
            end else if (slew_enable) begin
                // Reload rather than accumulate; a coincident half-chip is dropped.
                slew_cnt <= slew;
            end else if (slew_busy) begin
                // Swallow the half-chip: the replica is retarded by one half-chip.
                if (hc_enable) begin
                    slew_cnt <= slew_cnt - 11'd1;
                end
            end else if (hc_eff) begin
                early    <= ca;
                prompt   <= early;
                late     <= prompt;
                hc_phase <= ~hc_phase;
                if (hc_phase) begin
                    // Second half of the chip: advance to the next chip.
                    fc_enable <= 1'b1;
                    if (chip_cnt == LAST_CHIP) begin
                        chip_cnt    <= 10'd0;
                        g1          <= G1_INIT;
                        g2          <= prn_key;
                        dump_enable <= 1'b1;
                    end else begin
                        chip_cnt <= chip_cnt + 10'd1;
                        g1       <= {g1[8:0], g1_fb};
                        g2       <= {g2[8:0], g2_fb};
                    end
                end
            end
        end
    end

    // Measurement latch: captures the pre-edge code phase on each TIC.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            code_phase <= 11'd0;
        end else if (tic_enable) begin
            code_phase <= {chip_cnt, hc_phase};
        end
    end

endmodule

// File: tb/tb_ca_code_gen.sv
// Directed testbench for ca_code_gen. The expected code is produced by a
// bit-stream recurrence model of the G1/G2 sequences built inside the bench.
`timescale 1ns/1ps
module tb_ca_code_gen;

    logic        clk            = 1'b0;
    logic        rstn           = 1'b0;
    logic        hc_enable      = 1'b0;
    logic        tic_enable     = 1'b0;
    logic        prn_key_enable = 1'b0;
    logic [9:0]  prn_key        = 10'd0;
    logic        slew_enable    = 1'b0;
    logic [10:0] slew           = 11'd0;
    logic        fc_enable;
    logic        dump_enable;
    logic        early;
    logic        prompt;
    logic        late;
    logic [10:0] code_phase;
    logic        slew_busy;

    int checks = 0;
    int errors = 0;

    logic       o1     [0:1022];
    logic       o2     [0:1022];
    logic       ref_ca [0:1022];
    logic [9:0] g1_init = 10'h3FF;

    always #5 clk = ~clk;

    ca_code_gen dut (
        .clk            (clk),
        .rstn           (rstn),
        .hc_enable      (hc_enable),
        .tic_enable     (tic_enable),
        .prn_key_enable (prn_key_enable),
        .prn_key        (prn_key),
        .slew_enable    (slew_enable),
        .slew           (slew),
        .fc_enable      (fc_enable),
        .dump_enable    (dump_enable),
        .early          (early),
        .prompt         (prompt),
        .late           (late),
        .code_phase     (code_phase),
        .slew_busy      (slew_busy)
    );

    // Output streams of the two registers: o[n+10] follows from the feedback taps.
    task automatic build_ref(input logic [9:0] key);
        for (int i = 0; i < 10; i++) begin
            o1[i] = g1_init[9-i];
            o2[i] = key[9-i];
        end
        for (int n = 0; n + 10 < 1023; n++) begin
            o1[n+10] = o1[n+7] ^ o1[n];
            o2[n+10] = o2[n+8] ^ o2[n+7] ^ o2[n+4] ^ o2[n+2] ^ o2[n+1] ^ o2[n];
        end
        for (int n = 0; n < 1023; n++) ref_ca[n] = o1[n] ^ o2[n];
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic hc_pulse();
        hc_enable = 1'b1;
        @(posedge clk); #1;
        hc_enable = 1'b0;
    endtask

    task automatic tic_pulse();
        tic_enable = 1'b1;
        @(posedge clk); #1;
        tic_enable = 1'b0;
    endtask

    task automatic prn_load(input logic [9:0] key);
        prn_key        = key;
        prn_key_enable = 1'b1;
        @(posedge clk); #1;
        prn_key_enable = 1'b0;
    endtask

    task automatic test_reset();
        logic e_exp, e_prev, e_prev2, fc_exp;
        rstn = 1'b0;
        idle(3);
        checks++;
        if ({fc_enable, dump_enable, early, prompt, late, slew_busy, code_phase} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0",
                     {fc_enable, dump_enable, early, prompt, late, slew_busy, code_phase});
        end
        rstn = 1'b1;
        idle(1);
        build_ref(10'h3FF);
        prn_load(10'h3FF);
        e_prev  = 1'b0;
        e_prev2 = 1'b0;
        for (int k = 0; k < 48; k++) begin
            hc_pulse();
            e_exp  = ref_ca[k/2];
            fc_exp = (k % 2 == 1);
            checks++;
            if (early !== e_exp) begin
                errors++;
                $display("FAIL reset_early hc=%0d: got %b required %b", k, early, e_exp);
            end
            if (k < 20) begin
                checks++;
                if (early !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_early_zero hc=%0d: got %b required 0", k, early);
                end
            end
            checks++;
            if (prompt !== e_prev) begin
                errors++;
                $display("FAIL reset_prompt hc=%0d: got %b required %b", k, prompt, e_prev);
            end
            checks++;
            if (late !== e_prev2) begin
                errors++;
                $display("FAIL reset_late hc=%0d: got %b required %b", k, late, e_prev2);
            end
            checks++;
            if (fc_enable !== fc_exp) begin
                errors++;
                $display("FAIL reset_fc hc=%0d: got %b required %b", k, fc_enable, fc_exp);
            end
            idle(1);
            checks++;
            if (fc_enable !== 1'b0) begin
                errors++;
                $display("FAIL reset_fc_idle hc=%0d: got %b required 0", k, fc_enable);
            end
            idle(6);
            e_prev2 = e_prev;
            e_prev  = e_exp;
        end
    endtask

    task automatic test_epoch();
        int fc_cnt = 0, dump_cnt = 0, dump_at = 0, dump2 = 0, mism1 = 0, mism2 = 0;
        build_ref(10'h2A5);
        prn_load(10'h2A5);
        hc_enable = 1'b1;
        for (int k = 0; k < 4092; k++) begin
            @(posedge clk); #1;
            if (k < 2046) begin
                if (fc_enable) fc_cnt++;
                if (dump_enable) begin
                    dump_cnt++;
                    dump_at = fc_cnt;
                end
                if (early !== ref_ca[k/2]) mism1++;
            end else begin
                if (dump_enable) dump2++;
                if (early !== ref_ca[(k-2046)/2]) mism2++;
            end
            if (k == 2045) begin
                checks++;
                if (dut.g1 !== 10'h3FF) begin
                    errors++;
                    $display("FAIL epoch_g1_reload: got %h required 3ff", dut.g1);
                end
            end
        end
        hc_enable = 1'b0;
        checks++;
        if (fc_cnt != 1023) begin
            errors++;
            $display("FAIL epoch_fc_count: got %0d required 1023", fc_cnt);
        end
        checks++;
        if (dump_cnt != 1 || dump_at != 1023) begin
            errors++;
            $display("FAIL epoch_dump: got count %0d at fc %0d required count 1 at fc 1023", dump_cnt, dump_at);
        end
        checks++;
        if (mism1 != 0) begin
            errors++;
            $display("FAIL epoch1_sequence: got %0d chip errors required 0", mism1);
        end
        checks++;
        if (mism2 != 0) begin
            errors++;
            $display("FAIL epoch2_sequence: got %0d chip errors required 0", mism2);
        end
        checks++;
        if (dump2 != 1) begin
            errors++;
            $display("FAIL epoch2_dump: got %0d required 1", dump2);
        end
    endtask

    task automatic test_slew();
        int   eff = 0, busy_cnt = 0, mism = 0, dump_cnt = 0, dump_at = 0, fc_swallowed = 0;
        logic early_hold;
        build_ref(10'h1B3);
        prn_load(10'h1B3);
        for (int k = 0; k < 100; k++) begin
            hc_pulse();
            eff++;
        end
        checks++;
        if (early !== ref_ca[(eff-1)/2]) begin
            errors++;
            $display("FAIL slew_pre_early: got %b required %b", early, ref_ca[(eff-1)/2]);
        end
        slew        = 11'd5;
        slew_enable = 1'b1;
        @(posedge clk); #1;
        slew_enable = 1'b0;
        early_hold  = ref_ca[(eff-1)/2];
        for (int j = 0; j < 5; j++) begin
            if (slew_busy) busy_cnt++;
            hc_pulse();
            if (fc_enable) fc_swallowed++;
        end
        checks++;
        if (busy_cnt != 5 || slew_busy !== 1'b0) begin
            errors++;
            $display("FAIL slew_busy_span: got %0d busy pulses, busy now %b required 5 and 0", busy_cnt, slew_busy);
        end
        checks++;
        if (early !== early_hold || fc_swallowed != 0) begin
            errors++;
            $display("FAIL slew_frozen: got early %b fc %0d required %b and 0", early, fc_swallowed, early_hold);
        end
        for (int j = 0; j < 1950; j++) begin
            hc_pulse();
            eff++;
            if (early !== ref_ca[((eff-1) % 2046)/2]) mism++;
            if (dump_enable) begin
                dump_cnt++;
                dump_at = 105 + j + 1;
            end
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL slew_sequence: got %0d chip errors required 0", mism);
        end
        checks++;
        if (dump_cnt != 1 || dump_at != 2051) begin
            errors++;
            $display("FAIL slew_dump: got count %0d at hc %0d required 1 at hc 2051", dump_cnt, dump_at);
        end
    endtask

    task automatic test_tic();
        prn_load(10'h2A5);
        repeat (7) begin
            hc_pulse();
            idle(1);
        end
        tic_pulse();
        checks++;
        if (code_phase !== 11'd7) begin
            errors++;
            $display("FAIL tic_after7: got %0d required 7", code_phase);
        end
        hc_enable  = 1'b1;
        tic_enable = 1'b1;
        @(posedge clk); #1;
        hc_enable  = 1'b0;
        tic_enable = 1'b0;
        checks++;
        if (code_phase !== 11'd7 || fc_enable !== 1'b1) begin
            errors++;
            $display("FAIL tic_chip_step: got phase %0d fc %b required 7 and 1", code_phase, fc_enable);
        end
        tic_pulse();
        checks++;
        if (code_phase !== 11'd8) begin
            errors++;
            $display("FAIL tic_post_step: got %0d required 8", code_phase);
        end
        repeat (13) hc_pulse();
        tic_pulse();
        checks++;
        if (code_phase !== 11'd21) begin
            errors++;
            $display("FAIL tic_after21: got %0d required 21", code_phase);
        end
    endtask

    task automatic test_collisions();
        int busy_cnt = 0;
        build_ref(10'h1B3);
        prn_load(10'h1B3);
        repeat (3) hc_pulse();
        prn_key        = 10'h1B3;
        prn_key_enable = 1'b1;
        hc_enable      = 1'b1;
        @(posedge clk); #1;
        prn_key_enable = 1'b0;
        hc_enable      = 1'b0;
        checks++;
        if ({fc_enable, dump_enable, early, prompt, late} !== 5'b0) begin
            errors++;
            $display("FAIL coll_prn_outputs: got %b required 00000", {fc_enable, dump_enable, early, prompt, late});
        end
        tic_pulse();
        checks++;
        if (code_phase !== 11'd0) begin
            errors++;
            $display("FAIL coll_prn_phase: got %0d required 0", code_phase);
        end
        hc_pulse();
        checks++;
        if (early !== ref_ca[0] || fc_enable !== 1'b0) begin
            errors++;
            $display("FAIL coll_first_hc: got early %b fc %b required %b and 0", early, fc_enable, ref_ca[0]);
        end
        slew        = 11'd3;
        slew_enable = 1'b1;
        hc_enable   = 1'b1;
        @(posedge clk); #1;
        slew_enable = 1'b0;
        hc_enable   = 1'b0;
        checks++;
        if (dut.slew_cnt !== 11'd3 || fc_enable !== 1'b0 || slew_busy !== 1'b1) begin
            errors++;
            $display("FAIL coll_slew: got cnt %0d fc %b busy %b required 3, 0, 1", dut.slew_cnt, fc_enable, slew_busy);
        end
        for (int j = 0; j < 3; j++) begin
            if (slew_busy) busy_cnt++;
            hc_pulse();
        end
        checks++;
        if (busy_cnt != 3 || slew_busy !== 1'b0) begin
            errors++;
            $display("FAIL coll_slew_span: got %0d busy %b required 3 and 0", busy_cnt, slew_busy);
        end
        hc_pulse();
        checks++;
        if (fc_enable !== 1'b1 || early !== ref_ca[0]) begin
            errors++;
            $display("FAIL coll_after_slew: got fc %b early %b required 1 and %b", fc_enable, early, ref_ca[0]);
        end
        slew        = 11'd6;
        slew_enable = 1'b1;
        @(posedge clk); #1;
        slew_enable = 1'b0;
        repeat (2) hc_pulse();
        slew        = 11'd2;
        slew_enable = 1'b1;
        @(posedge clk); #1;
        slew_enable = 1'b0;
        checks++;
        if (dut.slew_cnt !== 11'd2) begin
            errors++;
            $display("FAIL coll_slew_reload: got %0d required 2", dut.slew_cnt);
        end
        repeat (2) hc_pulse();
        checks++;
        if (slew_busy !== 1'b0) begin
            errors++;
            $display("FAIL coll_reload_done: got busy %b required 0", slew_busy);
        end
        slew        = 11'd0;
        slew_enable = 1'b1;
        @(posedge clk); #1;
        slew_enable = 1'b0;
        checks++;
        if (slew_busy !== 1'b0) begin
            errors++;
            $display("FAIL coll_slew_zero: got busy %b required 0", slew_busy);
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] pre_exp;
        build_ref(10'h000);
        prn_load(10'h000);
        repeat (5) hc_pulse();
        tic_pulse();
        checks++;
        if (code_phase !== 11'd5) begin
            errors++;
            $display("FAIL areset_pre_phase: got %0d required 5", code_phase);
        end
        hc_pulse();
        pre_exp = {ref_ca[2], ref_ca[2], ref_ca[2], 1'b1};
        checks++;
        if ({early, prompt, late, fc_enable} !== pre_exp) begin
            errors++;
            $display("FAIL areset_pre_state: got %b required %b", {early, prompt, late, fc_enable}, pre_exp);
        end
        #3;
        rstn = 1'b0;
        #1;
        checks++;
        if ({fc_enable, dump_enable, early, prompt, late, slew_busy, code_phase} !== 17'd0) begin
            errors++;
            $display("FAIL areset_outputs: got %b required 0",
                     {fc_enable, dump_enable, early, prompt, late, slew_busy, code_phase});
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        idle(1);
        prn_load(10'h000);
        for (int k = 0; k < 4; k++) begin
            hc_pulse();
            checks++;
            if (early !== ref_ca[k/2]) begin
                errors++;
                $display("FAIL areset_restart hc=%0d: got %b required %b", k, early, ref_ca[k/2]);
            end
        end
        tic_pulse();
        checks++;
        if (code_phase !== 11'd4) begin
            errors++;
            $display("FAIL areset_restart_phase: got %0d required 4", code_phase);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_epoch();
        test_slew();
        test_tic();
        test_collisions();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ca_code_gen.md
# ca_code_gen

Consumer end of the code NCO half-chip interface. It takes the `hc_enable` strobe and produces the C/A Gold code replica for one tracking channel. It outputs early, prompt and late chips spaced one half-chip apart, plus a full-chip strobe and a 1 ms epoch (dump) strobe. It also supports PRN load, code slew (half-chip swallowing) and latches the code phase on the TIC for the measurement path.

## Interface
Parameters:
- `CODE_LEN`, 1023 — chips per code epoch; chip counter wraps at `CODE_LEN-1`.
- `G1_INIT`, 10'h3FF — G1 reload value.

Ports:
- `clk` in 1 — system clock (16.368 MHz).
- `rstn` in 1 — reset, asynchronous, active-low.
- `hc_enable` in 1 — one-cycle half-chip strobe from the code NCO.
- `tic_enable` in 1 — one-cycle measurement TIC strobe.
- `prn_key_enable` in 1 — one-cycle strobe; loads `prn_key` and restarts the code.
- `prn_key` in 10 — G2 initial state for the selected satellite.
- `slew_enable` in 1 — one-cycle strobe; loads `slew`.
- `slew` in 11 — number of half-chips to swallow (0..2047).
- `fc_enable` out 1 — one-cycle full-chip strobe.
- `dump_enable` out 1 — one-cycle epoch strobe.
- `early`, `prompt`, `late` out 1 each — code replica taps.
- `code_phase` out 11 — `{chip_cnt, hc_phase}` latched on TIC.
- `slew_busy` out 1 — high while `slew_cnt != 0`.

## Operation
- **LFSRs.** `g1[9:0]` and `g2[9:0]` shift left.
  - g1 feedback: `g1[2]^g1[9]`.
  - g2 feedback: `g2[1]^g2[2]^g2[5]^g2[7]^g2[8]^g2[9]`.
  - Code bit: `ca = g1[9]^g2[9]` (combinational).
- **Effective half-chip.** `hc_eff = hc_enable & ~slew_busy & ~slew_enable & ~prn_key_enable`.
- **On hc_eff:**
  - `early<=ca`, `prompt<=early`, `late<=prompt`.
  - `hc_phase` toggles.
- **Chip step.** This is an `hc_eff` with `hc_phase==1`.
  - `fc_enable<=1`.
  - If `chip_cnt==CODE_LEN-1`: set `chip_cnt<=0`, `g1<=G1_INIT`, `g2<=prn_key`, `dump_enable<=1`.
  - Otherwise: `chip_cnt++` and both LFSRs shift.
  - `fc_enable` and `dump_enable` are 0 in every other cycle.
- **PRN load.** On `prn_key_enable`:
  - `g1<=G1_INIT`, `g2<=prn_key`.
  - `chip_cnt<=0`, `hc_phase<=0`.
  - `early`, `prompt`, `late` cleared to 0.
  - `slew_cnt<=0`.
  - No `fc_enable` or `dump_enable` that cycle.
- **Slew.** On `slew_enable` (without `prn_key_enable`), `slew_cnt<=slew`. While `slew_cnt!=0`, each `hc_enable` decrements `slew_cnt` and is otherwise ignored. The effect is to retard the replica by `slew` half-chips.
- **TIC.** On `tic_enable`, `code_phase<={chip_cnt, hc_phase}`, sampled from the pre-edge values. Range is 0..2045.
- **Reset.** While `rstn` is low:
  - `g1=G1_INIT`, `g2=0`.
  - `chip_cnt`, `hc_phase`, `slew_cnt` = 0.
  - All outputs 0.
  - A PRN load is required after reset.

## Timing
- All outputs are registered. There is 1 cycle latency from the sampling edge of `hc_enable` to the `early`/`prompt`/`late` update and the `fc_enable`/`dump_enable` pulse.
- `dump_enable` is coincident with the `fc_enable` of the wrap step. The first chip of the new epoch appears on `early` at the next `hc_eff`.
- Priority, highest first:
  1. `prn_key_enable`
  2. `slew_enable`
  3. `slew_cnt` decrement
  4. `hc_eff`

  When a strobe overrides `hc_enable` in the same cycle, that `hc_enable` is dropped. It is neither counted nor decremented.
- `tic_enable` in the same cycle as a chip step latches the pre-step value.
- `slew_enable` while `slew_busy` reloads `slew_cnt` (no accumulation). `slew=0` leaves `slew_busy` low.
- Back-to-back `hc_enable` (every cycle) is supported. There is no minimum spacing.
- A reset assertion mid-epoch clears state immediately and asynchronously. Outputs are low from the reset edge.

## Test plan
- **Reset.** Reset, then `prn_key=10'h3FF` with `prn_key_enable`, then `hc_enable` every 8 cycles.
  - `early` is 0 for the first 20 half-chips (10 chips).
  - `prompt` lags `early` by exactly 1 hc and `late` by 2.
- **Epoch period.** Any `prn_key`, 2046 `hc_enable` pulses.
  - Exactly 1023 `fc_enable` pulses and one `dump_enable`, coincident with the 1023rd.
  - `g1==10'h3FF` after the wrap.
  - The second epoch's code sequence is identical to the first.
- **Slew.** `slew=5` mid-epoch.
  - `slew_busy` high for exactly 5 `hc_enable` pulses.
  - Following outputs are delayed by 5 half-chips versus an unslewed reference channel.
  - `dump_enable` is shifted 5 hc later.
- **TIC latch.** `tic_enable` after 7 hc from PRN load → `code_phase=11'd7`. `tic_enable` on the same cycle as a chip-step `hc_enable` → pre-step value latched.
- **Collisions.** `prn_key_enable` and `hc_enable` asserted together → no `fc_enable`, `chip_cnt=0`, `hc_phase=0`. `slew_enable(3)` and `hc_enable` asserted together → that `hc_enable` is dropped, `slew_cnt=3`.
- **Async reset.** Assert `rstn` low between clock edges mid-epoch → all outputs 0 before the next `clk` edge. Release then PRN load → sequence restarts at chip 0.
